// File: rtl/seqdet_ctrl_pkg.sv
// Shared types and default widths for the sequence-detector frame controller.
package seqdet_ctrl_pkg;

    localparam int W_DEF     = 8;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/seqdet_piso.sv
// Parallel-in serial-out shift register, MSB first, with a bit counter
// whose last flag marks the final bit of the frame.
import seqdet_ctrl_pkg::*;

module seqdet_piso #(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] data,
    output logic         sout,
    output logic         last
);

    localparam int BW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  r_shreg;
    logic [BW-1:0] r_bitcnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else if (load) begin
            r_shreg  <= data;
            r_bitcnt <= '0;
        end else if (shift) begin
            r_shreg  <= r_shreg << 1;
            r_bitcnt <= r_bitcnt + BW'(1);
        end
    end

    assign sout = r_shreg[W-1];
    assign last = (r_bitcnt == BW'(W - 1));

endmodule

// File: rtl/seqdet_frame_ctrl.sv
// Frame controller feeding a serial Mealy sequence detector and counting hits.
// Define SEQDET_FRAME_CLEAR_EN to clear the detector before every frame.
import seqdet_ctrl_pkg::*;

module seqdet_frame_ctrl #(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             det_din,
    output logic             det_clr,
    input  logic             det_dout,
    output logic             busy,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             done
);

`ifdef SEQDET_FRAME_CLEAR_EN
    localparam state_t S_FIRST = CLEAR;
`else
    localparam state_t S_FIRST = SHIFT;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_hit_cnt;
    logic             r_done;
    logic             w_load;
    logic             w_shift;
    logic             w_sout;
    logic             w_last;

    seqdet_piso #(
        .W(W)
    ) u_piso (
        .clk  (clk),
        .clr  (clr),
        .load (w_load),
        .shift(w_shift),
        .data (in_data),
        .sout (w_sout),
        .last (w_last)
    );

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_shift  = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b0;
        det_din  = 1'b0;
        det_clr  = clr;
        if (!clr) begin
            busy = (r_state != IDLE);
            unique case (r_state)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        w_load = 1'b1;
                        w_next = S_FIRST;
                    end
                end
`ifdef SEQDET_FRAME_CLEAR_EN
                CLEAR: begin
                    det_clr = 1'b1;
                    w_next  = SHIFT;
                end
`endif
                SHIFT: begin
                    det_din = w_sout;
                    w_shift = 1'b1;
                    if (w_last) w_next = DONE;
                end
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Counter saturates; it holds its final value until the next accept.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= IDLE;
            r_hit_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == DONE);
            if (w_load)
                r_hit_cnt <= '0;
            else if (w_shift && det_dout && r_hit_cnt != CNT_MAX)
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
    end

    assign hit_cnt = r_hit_cnt;
    assign done    = r_done;

endmodule
